// File: rtl/fir_seq_pkg.sv
// Shared widths, state encoding and coefficient table for the 31-tap symmetric FIR sequencer.
// Build option: define FIR_ROUND_EN for round-half-up output scaling (default truncates).
package fir_seq_pkg;

    localparam int unsigned DATA_W   = 10;
    localparam int unsigned COEF_W   = 12;
    localparam int unsigned ACC_W    = 28;
    localparam int unsigned NTAPS    = 31;
    localparam int unsigned NPAIRS   = 16;
    localparam int unsigned PTR_W    = 5;
    localparam int unsigned K_W      = 4;
    localparam int unsigned FRAC_W   = 15;
    localparam int unsigned PROD_W   = DATA_W + 1 + COEF_W;
    localparam int unsigned SCALED_W = ACC_W - FRAC_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } fir_state_t;

    // Half-filter coefficients, outermost tap pair first; k=15 is the centre tap.
    function automatic logic [COEF_W-1:0] coef_at(input logic [K_W-1:0] k);
        logic [COEF_W-1:0] c;
        c = 12'd2166;
        case (k)
            4'd0:    c = 12'd105;
            4'd1:    c = 12'd128;
            4'd2:    c = 12'd180;
            4'd3:    c = 12'd265;
            4'd4:    c = 12'd390;
            4'd5:    c = 12'd544;
            4'd6:    c = 12'd727;
            4'd7:    c = 12'd934;
            4'd8:    c = 12'd1150;
            4'd9:    c = 12'd1373;
            4'd10:   c = 12'd1586;
            4'd11:   c = 12'd1776;
            4'd12:   c = 12'd1940;
            4'd13:   c = 12'd2064;
            4'd14:   c = 12'd2140;
            default: c = 12'd2166;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample-in / filtered-out / status bundle between the capture front end and the FIR sequencer.
interface fir_mac_sequencer_if;
    import fir_seq_pkg::*;

    logic              sample_valid;
    logic [DATA_W-1:0] sample;
    logic              sample_ready;
    logic              filt_valid;
    logic [DATA_W-1:0] filt_data;
    logic              busy;
    logic              overrun;
    logic              overrun_clr;

    modport master (
        output sample_valid, sample, overrun_clr,
        input  sample_ready, filt_valid, filt_data, busy, overrun
    );

    modport slave (
        input  sample_valid, sample, overrun_clr,
        output sample_ready, filt_valid, filt_data, busy, overrun
    );

endinterface

// File: rtl/fir_sample_ring.sv
// 31-entry circular sample history with one write port and two reads addressed relative to the newest sample.
module fir_sample_ring
    import fir_seq_pkg::*;
(
    input  logic              clk,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]  off_a_i,
    input  logic [PTR_W-1:0]  off_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] mem_q [NTAPS];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  newest_c;
    logic [PTR_W-1:0]  idx_a_c;
    logic [PTR_W-1:0]  idx_b_c;

    // (base - off) mod 31 for base, off in 0..30
    function automatic logic [PTR_W-1:0] step_back(input logic [PTR_W-1:0] base,
                                                   input logic [PTR_W-1:0] off);
        logic [PTR_W:0] s;
        s = {1'b0, base} + (PTR_W+1)'(NTAPS) - {1'b0, off};
        if (s >= (PTR_W+1)'(NTAPS)) begin
            s = s - (PTR_W+1)'(NTAPS);
        end
        return s[PTR_W-1:0];
    endfunction

    always_comb begin
        newest_c  = step_back(wr_ptr_q, PTR_W'(1));
        idx_a_c   = step_back(newest_c, off_a_i);
        idx_b_c   = step_back(newest_c, off_b_i);
        rdata_a_o = mem_q[idx_a_c];
        rdata_b_o = mem_q[idx_b_c];
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < int'(NTAPS); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
        end else if (we_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= (wr_ptr_q == PTR_W'(NTAPS - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed 31-tap symmetric FIR: one shared multiplier walks 16 tap pairs per accepted sample.
// Build option: FIR_ROUND_EN selects round-half-up scaling of the accumulator; undefined truncates.
module fir_mac_sequencer
    import fir_seq_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    fir_mac_sequencer_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_MAC  = 2'(MAC);
    localparam logic [1:0] S_DONE = 2'(DONE);

    logic [1:0]          state_q, state_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [DATA_W-1:0]   filt_data_q, filt_data_d;
    logic                filt_valid_q, filt_valid_d;
    logic                overrun_q, overrun_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;

    logic                ring_we_c;
    logic [PTR_W-1:0]    off_a_c, off_b_c;
    logic [DATA_W-1:0]   x_a_c, x_b_c;
    logic [DATA_W:0]     pair_sum_c;
    logic [PROD_W-1:0]   term_c;
    logic [ACC_W-1:0]    acc_r_c;
    logic [SCALED_W-1:0] scaled_c;
    logic [DATA_W-1:0]   sat_c;

    fir_sample_ring u_ring (
        .clk       (clk),
        .clr_i     (reset),
        .we_i      (ring_we_c),
        .wdata_i   (bus.sample),
        .off_a_i   (off_a_c),
        .off_b_i   (off_b_c),
        .rdata_a_o (x_a_c),
        .rdata_b_o (x_b_c)
    );

    // Tap pair k reads x[n-k] and x[n-30+k]; the centre tap (k=15) is used alone.
    always_comb begin
        off_a_c    = {1'b0, k_q};
        off_b_c    = PTR_W'(NTAPS - 1) - {1'b0, k_q};
        pair_sum_c = (k_q == K_W'(NPAIRS - 1)) ? {1'b0, x_a_c}
                                               : {1'b0, x_a_c} + {1'b0, x_b_c};
        term_c     = PROD_W'(pair_sum_c) * PROD_W'(coef_at(k_q));
    end

    always_comb begin
`ifdef FIR_ROUND_EN
        acc_r_c = acc_q + ACC_W'(1 << (FRAC_W - 1));
`else
        acc_r_c = acc_q;
`endif
        scaled_c = acc_r_c[ACC_W-1:FRAC_W];
        sat_c    = (|scaled_c[SCALED_W-1:DATA_W]) ? '1 : scaled_c[DATA_W-1:0];
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        acc_d        = acc_q;
        filt_data_d  = filt_data_q;
        filt_valid_d = 1'b0;
        overrun_d    = overrun_q;
        ring_we_c    = 1'b0;

        // A drop in the same cycle as a clear keeps the flag set.
        if (bus.sample_valid && !ready_q) begin
            overrun_d = 1'b1;
        end else if (bus.overrun_clr) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.sample_valid) begin
                    ring_we_c = 1'b1;
                    acc_d     = '0;
                    k_d       = '0;
                    state_d   = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + ACC_W'(term_c);
                if (k_q == K_W'(NPAIRS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            S_DONE: begin
                filt_data_d  = sat_c;
                filt_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            acc_q        <= '0;
            filt_data_q  <= '0;
            filt_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            filt_data_q  <= filt_data_d;
            filt_valid_q <= filt_valid_d;
            overrun_q    <= overrun_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.sample_ready = ready_q;
    assign bus.busy         = busy_q;
    assign bus.filt_valid   = filt_valid_q;
    assign bus.filt_data    = filt_data_q;
    assign bus.overrun      = overrun_q;

endmodule
